// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM states, access-size
// encodings, control-bus bit positions and the alignment rule.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Access size encodings carried on size_in
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // mem_control = {branch, mem_read, mem_write}
  localparam int MC_BRANCH    = 2;
  localparam int MC_MEM_READ  = 1;
  localparam int MC_MEM_WRITE = 0;

  // wb_control = {reg_write, mem_to_reg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // An access is misaligned when the address is not a multiple of its size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] addr_lo);
    case (size)
      SZ_H:    is_misaligned = addr_lo[0];
      SZ_W:    is_misaligned = |addr_lo[1:0];
      SZ_D:    is_misaligned = |addr_lo;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for the data memory: shifts store data/strobes into their byte
// lanes and extracts + sign/zero-extends load data from the returned word.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: size/offset/is_unsigned select the access; st_data -> st_wdata/st_wstrb;
//        ld_raw -> ld_data.
module mem_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [1:0]                        size,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   offset,
  input  logic                              is_unsigned,
  input  logic [DATA_WIDTH-1:0]             st_data,
  input  logic [DATA_WIDTH-1:0]             ld_raw,
  output logic [DATA_WIDTH-1:0]             st_wdata,
  output logic [DATA_WIDTH/8-1:0]           st_wstrb,
  output logic [DATA_WIDTH-1:0]             ld_data
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [STRB_W-1:0]     base_mask;
  logic [DATA_WIDTH-1:0] ld_shifted;

  always_comb begin
    base_mask = '0;
    case (size)
      SZ_B:    base_mask = STRB_W'(8'h01);
      SZ_H:    base_mask = STRB_W'(8'h03);
      SZ_W:    base_mask = STRB_W'(8'h0F);
      default: base_mask = STRB_W'(8'hFF);
    endcase
  end

  assign st_wstrb   = base_mask << offset;
  assign st_wdata   = st_data << {offset, 3'b000};
  assign ld_shifted = ld_raw >> {offset, 3'b000};

  always_comb begin
    ld_data = ld_shifted;
    case (size)
      SZ_B: ld_data = is_unsigned ? {{(DATA_WIDTH-8){1'b0}},  ld_shifted[7:0]}
                                  : {{(DATA_WIDTH-8){ld_shifted[7]}},  ld_shifted[7:0]};
      SZ_H: ld_data = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, ld_shifted[15:0]}
                                  : {{(DATA_WIDTH-16){ld_shifted[15]}}, ld_shifted[15:0]};
      SZ_W: ld_data = is_unsigned ? {{(DATA_WIDTH-32){1'b0}}, ld_shifted[31:0]}
                                  : {{(DATA_WIDTH-32){ld_shifted[31]}}, ld_shifted[31:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store, resolves
// taken branches, and hands results to the MEM/WB register.
// Latency: non-memory/misaligned 1 cycle; store 1 + ready wait; load adds response wait.
// Backpressure: stall is high whenever a memory access is in flight (state != IDLE).
// Ports: in_* (EX/MEM fields, sampled only when idle), dmem_req_* / dmem_resp_*
//        (valid-ready request, valid-only response), wb_* (result), redirect_* (branch).
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     alu_res_in,
  input  logic [DATA_WIDTH-1:0]     write_data_in,
  input  logic [DATA_WIDTH-1:0]     target_in,
  input  logic                      branch_decision_in,
  input  logic [2:0]                mem_control_in,
  input  logic [1:0]                wb_control_in,
  input  logic [REG_ID_WIDTH-1:0]   dest_in,
  input  logic [1:0]                size_in,
  input  logic                      unsigned_in,
  output logic                      stall,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_target,
  output logic                      dmem_req_valid,
  input  logic                      dmem_req_ready,
  output logic [DATA_WIDTH-1:0]     dmem_req_addr,
  output logic                      dmem_req_we,
  output logic [DATA_WIDTH-1:0]     dmem_req_wdata,
  output logic [DATA_WIDTH/8-1:0]   dmem_req_wstrb,
  input  logic                      dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     dmem_resp_data,
  output logic                      wb_valid,
  output logic [DATA_WIDTH-1:0]     wb_alu_res,
  output logic [DATA_WIDTH-1:0]     wb_load_data,
  output logic [REG_ID_WIDTH-1:0]   wb_dest,
  output logic [1:0]                wb_control,
  output logic                      wb_misaligned
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     alu_res_q, alu_res_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      is_store_q, is_store_d;
  logic [1:0]                wb_ctl_q, wb_ctl_d;
  logic [REG_ID_WIDTH-1:0]   dest_q, dest_d;
  logic [1:0]                size_q, size_d;
  logic                      uns_q, uns_d;

  logic                      redirect_valid_q, redirect_valid_d;
  logic [DATA_WIDTH-1:0]     redirect_target_q, redirect_target_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0]     wb_alu_res_q, wb_alu_res_d;
  logic [DATA_WIDTH-1:0]     wb_load_data_q, wb_load_data_d;
  logic [REG_ID_WIDTH-1:0]   wb_dest_q, wb_dest_d;
  logic [1:0]                wb_control_q, wb_control_d;
  logic                      wb_misaligned_q, wb_misaligned_d;

  logic [DATA_WIDTH-1:0]     al_wdata;
  logic [STRB_W-1:0]         al_wstrb;
  logic [DATA_WIDTH-1:0]     al_ld_data;
  logic                      in_is_mem;
  logic                      in_misaligned;
  logic                      in_req;

  // Lane logic always works from the latched instruction, so the request
  // fields cannot move while the memory is still deciding to accept them.
  mem_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size        (size_q),
    .offset      (alu_res_q[OFF_W-1:0]),
    .is_unsigned (uns_q),
    .st_data     (wdata_q),
    .ld_raw      (dmem_resp_data),
    .st_wdata    (al_wdata),
    .st_wstrb    (al_wstrb),
    .ld_data     (al_ld_data)
  );

  assign in_is_mem     = mem_control_in[MC_MEM_READ] | mem_control_in[MC_MEM_WRITE];
  assign in_misaligned = is_misaligned(size_in, alu_res_in[2:0]);
  assign in_req        = (state_q == ST_REQ);

  always_comb begin
    state_d           = state_q;
    alu_res_d         = alu_res_q;
    wdata_d           = wdata_q;
    is_store_d        = is_store_q;
    wb_ctl_d          = wb_ctl_q;
    dest_d            = dest_q;
    size_d            = size_q;
    uns_d             = uns_q;
    redirect_valid_d  = 1'b0;
    redirect_target_d = redirect_target_q;
    wb_valid_d        = 1'b0;
    wb_alu_res_d      = wb_alu_res_q;
    wb_load_data_d    = wb_load_data_q;
    wb_dest_d         = wb_dest_q;
    wb_control_d      = wb_control_q;
    wb_misaligned_d   = wb_misaligned_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          alu_res_d  = alu_res_in;
          wdata_d    = write_data_in;
          is_store_d = mem_control_in[MC_MEM_WRITE];
          wb_ctl_d   = wb_control_in;
          dest_d     = dest_in;
          size_d     = size_in;
          uns_d      = unsigned_in;

          if (mem_control_in[MC_BRANCH] && branch_decision_in) begin
            redirect_valid_d  = 1'b1;
            redirect_target_d = target_in;
          end

          if (in_is_mem && !in_misaligned) begin
            state_d = ST_REQ;
          end else begin
            // Non-memory ops and faulting accesses retire straight away; a
            // faulting access must not write the register file.
            wb_valid_d      = 1'b1;
            wb_alu_res_d    = alu_res_in;
            wb_dest_d       = dest_in;
            wb_misaligned_d = in_is_mem;
            wb_control_d    = wb_control_in;
            if (in_is_mem) begin
              wb_control_d[WB_REG_WRITE] = 1'b0;
            end
          end
        end
      end

      ST_REQ: begin
        if (dmem_req_ready) begin
          if (is_store_q) begin
            state_d         = ST_IDLE;
            wb_valid_d      = 1'b1;
            wb_alu_res_d    = alu_res_q;
            wb_dest_d       = dest_q;
            wb_control_d    = wb_ctl_q;
            wb_misaligned_d = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (dmem_resp_valid) begin
          state_d         = ST_IDLE;
          wb_valid_d      = 1'b1;
          wb_alu_res_d    = alu_res_q;
          wb_load_data_d  = al_ld_data;
          wb_dest_d       = dest_q;
          wb_control_d    = wb_ctl_q;
          wb_misaligned_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      alu_res_q         <= '0;
      wdata_q           <= '0;
      is_store_q        <= 1'b0;
      wb_ctl_q          <= '0;
      dest_q            <= '0;
      size_q            <= '0;
      uns_q             <= 1'b0;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
      wb_valid_q        <= 1'b0;
      wb_alu_res_q      <= '0;
      wb_load_data_q    <= '0;
      wb_dest_q         <= '0;
      wb_control_q      <= '0;
      wb_misaligned_q   <= 1'b0;
    end else begin
      state_q           <= state_d;
      alu_res_q         <= alu_res_d;
      wdata_q           <= wdata_d;
      is_store_q        <= is_store_d;
      wb_ctl_q          <= wb_ctl_d;
      dest_q            <= dest_d;
      size_q            <= size_d;
      uns_q             <= uns_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_target_q <= redirect_target_d;
      wb_valid_q        <= wb_valid_d;
      wb_alu_res_q      <= wb_alu_res_d;
      wb_load_data_q    <= wb_load_data_d;
      wb_dest_q         <= wb_dest_d;
      wb_control_q      <= wb_control_d;
      wb_misaligned_q   <= wb_misaligned_d;
    end
  end

  assign stall           = (state_q != ST_IDLE);
  assign redirect_valid  = redirect_valid_q;
  assign redirect_target = redirect_target_q;

  // Request fields are forced to zero outside REQ so reset leaves every output at 0.
  assign dmem_req_valid = in_req;
  assign dmem_req_addr  = in_req ? {alu_res_q[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign dmem_req_we    = in_req & is_store_q;
  assign dmem_req_wdata = in_req ? al_wdata : '0;
  assign dmem_req_wstrb = in_req ? al_wstrb : '0;

  assign wb_valid      = wb_valid_q;
  assign wb_alu_res    = wb_alu_res_q;
  assign wb_load_data  = wb_load_data_q;
  assign wb_dest       = wb_dest_q;
  assign wb_control    = wb_control_q;
  assign wb_misaligned = wb_misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// load/store/ALU/branch traffic checked against a behavioural model.
module tb_mem_stage;

  localparam int DW = 64;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] alu_res_in, write_data_in, target_in;
  logic          branch_decision_in;
  logic [2:0]    mem_control_in;
  logic [1:0]    wb_control_in;
  logic [RW-1:0] dest_in;
  logic [1:0]    size_in;
  logic          unsigned_in;
  logic          stall, redirect_valid;
  logic [DW-1:0] redirect_target;
  logic          dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [DW-1:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]    dmem_req_wstrb;
  logic          dmem_resp_valid;
  logic [DW-1:0] dmem_resp_data;
  logic          wb_valid, wb_misaligned;
  logic [DW-1:0] wb_alu_res, wb_load_data;
  logic [RW-1:0] wb_dest;
  logic [1:0]    wb_control;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_WIDTH(DW), .REG_ID_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .alu_res_in(alu_res_in), .write_data_in(write_data_in), .target_in(target_in),
    .branch_decision_in(branch_decision_in), .mem_control_in(mem_control_in),
    .wb_control_in(wb_control_in), .dest_in(dest_in), .size_in(size_in),
    .unsigned_in(unsigned_in), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr),
    .dmem_req_we(dmem_req_we), .dmem_req_wdata(dmem_req_wdata),
    .dmem_req_wstrb(dmem_req_wstrb), .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data(dmem_resp_data), .wb_valid(wb_valid), .wb_alu_res(wb_alu_res),
    .wb_load_data(wb_load_data), .wb_dest(wb_dest), .wb_control(wb_control),
    .wb_misaligned(wb_misaligned)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [63:0] model_load(input logic [63:0] raw, input int off,
                                             input int size, input bit uns);
    int            bits = 8 * (1 << size);
    logic [63:0]   v    = raw >> (8 * off);
    logic [63:0]   keep;
    if (bits == 64) return v;
    keep = (64'd1 << bits) - 64'd1;
    v    = v & keep;
    if (!uns && v[bits-1]) v = v | ~keep;
    return v;
  endfunction

  function automatic logic [7:0] model_wstrb(input int off, input int size);
    int m = (1 << (1 << size)) - 1;
    return 8'((m << off) & 255);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic scramble();
    alu_res_in         = {$urandom, $urandom};
    write_data_in      = {$urandom, $urandom};
    target_in          = {$urandom, $urandom};
    branch_decision_in = 1'($urandom);
    mem_control_in     = 3'($urandom);
    wb_control_in      = 2'($urandom);
    dest_in            = RW'($urandom);
    size_in            = 2'($urandom);
    unsigned_in        = 1'($urandom);
  endtask

  // kind: 0 = ALU op, 1 = load, 2 = store
  task automatic do_op(input int kind, input logic [63:0] addr, input logic [63:0] data,
                       input int size, input bit uns, input bit br, input bit taken,
                       input logic [63:0] tgt, input logic [RW-1:0] dest,
                       input logic [1:0] wbc, input int rdly, input int wdly,
                       input logic [63:0] resp);
    int          off   = int'(addr[2:0]);
    int          bytes = 1 << size;
    bit          mis   = (kind != 0) && ((addr % 64'(bytes)) != 0);
    logic [63:0] exp_addr = addr & ~64'h7;

    in_valid = 1'b1; alu_res_in = addr; write_data_in = data; target_in = tgt;
    branch_decision_in = taken; mem_control_in = {br, kind == 1, kind == 2};
    wb_control_in = wbc; dest_in = dest; size_in = 2'(size); unsigned_in = uns;
    tick();
    check("redirect_valid", redirect_valid, br && taken);
    if (br && taken) check("redirect_target", redirect_target, tgt);

    if (kind == 0 || mis) begin
      in_valid = 1'b0; scramble();
      check("wb_valid_imm", wb_valid, 1);
      check("wb_misaligned", wb_misaligned, mis);
      check("wb_control_imm", wb_control, mis ? {1'b0, wbc[0]} : wbc);
      check("wb_dest_imm", wb_dest, dest);
      check("wb_alu_res_imm", wb_alu_res, addr);
      check("stall_idle", stall, 0);
      check("no_req", dmem_req_valid, 0);
    end else begin
      scramble(); in_valid = 1'b1;   // ignored while busy
      check("stall_req", stall, 1);
      check("req_valid", dmem_req_valid, 1);
      check("req_addr", dmem_req_addr, exp_addr);
      check("req_we", dmem_req_we, kind == 2);
      check("req_wstrb", dmem_req_wstrb, model_wstrb(off, size));
      if (kind == 2) check("req_wdata", dmem_req_wdata, data << (8 * off));
      for (int i = 0; i < rdly; i++) begin
        tick(); scramble();
        check("redirect_pulse", redirect_valid, 0);
        check("req_hold_valid", dmem_req_valid, 1);
        check("req_hold_addr", dmem_req_addr, exp_addr);
      end
      // A response coinciding with the handshake must be ignored.
      dmem_req_ready = 1'b1; dmem_resp_valid = 1'b1; dmem_resp_data = {$urandom, $urandom};
      tick();
      dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
      if (kind == 2) begin
        in_valid = 1'b0;
        check("wb_valid_st", wb_valid, 1);
        check("stall_st_done", stall, 0);
        check("wb_dest_st", wb_dest, dest);
        check("wb_control_st", wb_control, wbc);
        check("wb_alu_res_st", wb_alu_res, addr);
      end else begin
        check("stall_wait", stall, 1);
        check("wait_no_req", dmem_req_valid, 0);
        check("wait_no_wb", wb_valid, 0);
        for (int i = 0; i < wdly; i++) begin
          tick();
          check("stall_wait_hold", stall, 1);
          check("wait_no_wb_hold", wb_valid, 0);
        end
        dmem_resp_valid = 1'b1; dmem_resp_data = resp;
        tick();
        dmem_resp_valid = 1'b0; in_valid = 1'b0;
        check("wb_valid_ld", wb_valid, 1);
        check("wb_load_data", wb_load_data, model_load(resp, off, size, uns));
        check("wb_dest_ld", wb_dest, dest);
        check("wb_control_ld", wb_control, wbc);
        check("wb_misaligned_ld", wb_misaligned, 0);
        check("stall_ld_done", stall, 0);
      end
    end
    tick();
    check("wb_valid_pulse", wb_valid, 0);
    check("redirect_off", redirect_valid, 0);
    check("wb_dest_hold", wb_dest, dest);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0; dmem_resp_data = '0;
    scramble();
    tick(); tick();
    reset = 1'b0;
    check("rst_stall", stall, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_req_valid", dmem_req_valid, 0);
    check("rst_wstrb", dmem_req_wstrb, 0);
    check("rst_wb_alu_res", wb_alu_res, 0);
    check("rst_redirect_tgt", redirect_target, 0);

    // SD aligned, ready at once
    do_op(2, 64'h1000, 64'hDEADBEEF_CAFEF00D, 3, 0, 0, 0, 0, 5'd3, 2'b00, 0, 0, 0);
    // LB signed, response after 3 WAIT cycles
    do_op(1, 64'h1003, 0, 0, 0, 0, 0, 0, 5'd7, 2'b11, 1, 3, 64'h00000000_80000000);
    // SH upper lanes
    do_op(2, 64'h1006, 64'h1234, 1, 0, 0, 0, 0, 5'd9, 2'b00, 2, 0, 0);
    // LW misaligned
    do_op(1, 64'h1002, 0, 2, 0, 0, 0, 0, 5'd4, 2'b11, 0, 0, 0);
    // taken branch, then a not-taken one
    do_op(0, 64'h0, 0, 0, 0, 1, 1, 64'h2000, 5'd0, 2'b00, 0, 0, 0);
    do_op(0, 64'h55, 0, 0, 0, 1, 0, 64'h3000, 5'd1, 2'b10, 0, 0, 0);

    // response while idle is ignored
    dmem_resp_valid = 1'b1; tick(); dmem_resp_valid = 1'b0;
    check("idle_resp_ignored", wb_valid, 0);

    for (int n = 0; n < 60; n++) begin
      int          kind = $urandom_range(0, 2);
      int          size = $urandom_range(0, 3);
      logic [63:0] addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'((1 << size) - 1);
      do_op(kind, addr, {$urandom, $urandom}, size, 1'($urandom), 1'($urandom),
            1'($urandom), {$urandom, $urandom}, RW'($urandom), 2'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
    end

    // reset while waiting for a load, then a late response
    in_valid = 1'b1; alu_res_in = 64'h4000; mem_control_in = 3'b010; size_in = 2'd3;
    wb_control_in = 2'b11; dest_in = 5'd12; branch_decision_in = 1'b0;
    tick();
    in_valid = 1'b0; dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    check("pre_rst_wait", stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_wait_stall", stall, 0);
    check("rst_wait_wb_valid", wb_valid, 0);
    check("rst_wait_wb_dest", wb_dest, 0);
    check("rst_wait_load_data", wb_load_data, 0);
    dmem_resp_valid = 1'b1; dmem_resp_data = 64'hFFFF;
    tick();
    dmem_resp_valid = 1'b0;
    check("late_resp_no_wb", wb_valid, 0);
    check("late_resp_stall", stall, 0);
    check("late_resp_load_data", wb_load_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 64, datapath and memory word width
- REG_ID_WIDTH, 5, destination register ID width
REQ-002 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  EX/MEM register holds a live instruction
- alu_res_in  in  DATA_WIDTH  ALU result / memory address
- write_data_in  in  DATA_WIDTH  store data
- target_in  in  DATA_WIDTH  branch target
- branch_decision_in  in  1  ALU branch outcome
- mem_control_in  in  3  {branch, mem_read, mem_write}
- wb_control_in  in  2  {reg_write, mem_to_reg}
- dest_in  in  REG_ID_WIDTH  destination register
- size_in  in  2  access size: 0=B, 1=H, 2=W, 3=D
- unsigned_in  in  1  zero-extend load
- stall  out  1  hold upstream stages
- redirect_valid  out  1  taken-branch pulse
- redirect_target  out  DATA_WIDTH  fetch target
- dmem_req_valid  out  1  memory request
- dmem_req_ready  in  1  memory accepts request
- dmem_req_addr  out  DATA_WIDTH  8-byte-aligned address
- dmem_req_we  out  1  write enable
- dmem_req_wdata  out  DATA_WIDTH  lane-shifted store data
- dmem_req_wstrb  out  DATA_WIDTH/8  byte enables
- dmem_resp_valid  in  1  load data returned
- dmem_resp_data  in  DATA_WIDTH  load data
- wb_valid  out  1  result to MEM/WB register
- wb_alu_res  out  DATA_WIDTH  ALU result passthrough
- wb_load_data  out  DATA_WIDTH  extended load data
- wb_dest  out  REG_ID_WIDTH  destination
- wb_control  out  2  {reg_write, mem_to_reg}
- wb_misaligned  out  1  access faulted on alignment

Function
REQ-003 The FSM SHALL have states IDLE, REQ and WAIT; instructions SHALL be accepted only in IDLE with in_valid=1.
REQ-004 At acceptance, all inputs SHALL be latched into internal registers; later input changes SHALL NOT affect the instruction in flight.
REQ-005 A non-memory instruction (mem_read=mem_write=0) SHALL stay in IDLE; wb_valid=1 with its latched fields one cycle after acceptance.
REQ-006 If branch=1 and branch_decision_in=1 at acceptance, the block SHALL assert redirect_valid=1 with redirect_target=target_in for exactly one cycle, one cycle after acceptance.
REQ-007 If the address is not a multiple of the access size (1/2/4/8 bytes), the block SHALL issue no request, SHALL set wb_valid=1 with wb_misaligned=1 and wb_control[1]=0 one cycle later, and SHALL stay in IDLE.
REQ-008 An aligned load or store SHALL move IDLE->REQ; stall SHALL be 1 whenever state != IDLE and 0 in IDLE.
REQ-009 In REQ, dmem_req_valid SHALL be 1; addr, we, wdata and wstrb SHALL stay stable until dmem_req_ready=1 and SHALL never be retracted.
REQ-010 dmem_req_addr SHALL be the address with bits [2:0] cleared; offset = address[2:0].
REQ-011 wstrb SHALL be the size mask (0x01/0x03/0x0F/0xFF) shifted left by offset, and wdata SHALL be write_data shifted left by 8*offset.
REQ-012 A store handshake in REQ SHALL move the FSM to IDLE and pulse wb_valid on the next cycle.
REQ-013 A load handshake in REQ SHALL move the FSM to WAIT; dmem_resp_valid in WAIT SHALL move it to IDLE and pulse wb_valid on the next cycle.
REQ-014 wb_load_data SHALL be dmem_resp_data shifted right by 8*offset and truncated to size, then sign-extended (unsigned_in=0) or zero-extended (unsigned_in=1) to DATA_WIDTH.
REQ-015 dmem_resp_valid outside WAIT SHALL be ignored.
REQ-016 A response in the same cycle as the handshake SHALL NOT be accepted; at most one request SHALL be outstanding.
REQ-017 wb_valid and redirect_valid SHALL be one-cycle pulses; all other wb_* outputs SHALL hold their last values.

Reset
REQ-018 On reset the FSM SHALL return to IDLE from any state, abandoning any outstanding request; a later response SHALL be ignored per REQ-015.
REQ-019 On reset all outputs and internal registers SHALL be 0.

Structure
REQ-020 Package mem_pkg SHALL hold the FSM state enum, size encodings and mem_control/wb_control bit-index constants.
REQ-021 Store lane alignment, load extraction and extension SHALL be one combinational sub-module, mem_align.

Verification
REQ-022 Scenario: SD addr 0x1000, data 0xDEADBEEF_CAFEF00D, ready at once -> req addr 0x1000, wstrb 0xFF; wb_valid 2 cycles after acceptance.
REQ-023 Scenario: LB addr 0x1003 signed, resp 0x00000000_80000000 after 3 WAIT cycles -> wb_load_data 0xFFFF_FFFF_FFFF_FF80; stall high throughout.
REQ-024 Scenario: SH addr 0x1006, data 0x1234 -> wstrb 0xC0, wdata bits[63:48]=0x1234.
REQ-025 Scenario: LW addr 0x1002 -> no dmem_req_valid; wb_misaligned=1 and wb_control[1]=0 next cycle.
REQ-026 Scenario: taken branch to 0x2000 -> redirect_valid pulse with target 0x2000; reset during WAIT, then late response -> IDLE, no wb_valid.
